// File: rtl/maze_game_if.sv
// Player-facing signal bundle for maze_game: direction requests in, game status out.
interface maze_game_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int MOVE_LIMIT = 12
);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int MOVES_W = $clog2(MOVE_LIMIT + 1);

  logic               n;
  logic               s;
  logic               e;
  logic               w;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic               sword;
  logic               slain;
  logic [MOVES_W-1:0] moves;
  logic               d;
  logic               win;

  modport master (
    output n, s, e, w,
    input  row, col, sword, slain, moves, d, win
  );

  modport slave (
    input  n, s, e, w,
    output row, col, sword, slain, moves, d, win
  );
endinterface

// File: rtl/maze_game.sv
// Grid adventure controller: walk the grid, grab the sword, slay the dragon, reach the exit.
// Optional accepted-move budget enabled by defining MAZE_GAME_MOVE_LIMIT_EN.
module maze_game #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int START_ROW  = 0,
  parameter int START_COL  = 0,
  parameter int SWORD_ROW  = 3,
  parameter int SWORD_COL  = 0,
  parameter int DRAGON_ROW = 3,
  parameter int DRAGON_COL = 3,
  parameter int EXIT_ROW   = 0,
  parameter int EXIT_COL   = 3,
  parameter int MOVE_LIMIT = 12
) (
  input  logic         clock,
  input  logic         R,
  maze_game_if.slave   bus
);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int MOVES_W = $clog2(MOVE_LIMIT + 1);

  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] START_R  = ROW_W'(START_ROW);
  localparam logic [COL_W-1:0] START_C  = COL_W'(START_COL);
  localparam logic [ROW_W-1:0] SWORD_R  = ROW_W'(SWORD_ROW);
  localparam logic [COL_W-1:0] SWORD_C  = COL_W'(SWORD_COL);
  localparam logic [ROW_W-1:0] DRAGON_R = ROW_W'(DRAGON_ROW);
  localparam logic [COL_W-1:0] DRAGON_C = COL_W'(DRAGON_COL);
  localparam logic [ROW_W-1:0] EXIT_R   = ROW_W'(EXIT_ROW);
  localparam logic [COL_W-1:0] EXIT_C   = COL_W'(EXIT_COL);

  if (ROWS < 2 || COLS < 2) begin : g_bad_dims
    $error("maze_game: ROWS and COLS must both be at least 2");
  end
  if (START_ROW < 0 || START_ROW >= ROWS || START_COL < 0 || START_COL >= COLS ||
      SWORD_ROW < 0 || SWORD_ROW >= ROWS || SWORD_COL < 0 || SWORD_COL >= COLS ||
      DRAGON_ROW < 0 || DRAGON_ROW >= ROWS || DRAGON_COL < 0 || DRAGON_COL >= COLS ||
      EXIT_ROW < 0 || EXIT_ROW >= ROWS || EXIT_COL < 0 || EXIT_COL >= COLS) begin : g_bad_coord
    $error("maze_game: a room coordinate lies outside the grid");
  end
  if ((START_ROW == SWORD_ROW && START_COL == SWORD_COL) ||
      (START_ROW == DRAGON_ROW && START_COL == DRAGON_COL) ||
      (START_ROW == EXIT_ROW && START_COL == EXIT_COL) ||
      (SWORD_ROW == DRAGON_ROW && SWORD_COL == DRAGON_COL) ||
      (SWORD_ROW == EXIT_ROW && SWORD_COL == EXIT_COL) ||
      (DRAGON_ROW == EXIT_ROW && DRAGON_COL == EXIT_COL)) begin : g_bad_rooms
    $error("maze_game: start, sword, dragon and exit rooms must all be distinct");
  end

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    DEAD = 2'd1,
    WON  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               sword_q, sword_d;
  logic               slain_q, slain_d;
  logic [MOVES_W-1:0] moves_q, moves_d;
  logic               d_q, d_d;
  logic               win_q, win_d;

  logic               valid_req;
  logic               blocked;
  logic               accept;
  logic [ROW_W-1:0]   tgt_row;
  logic [COL_W-1:0]   tgt_col;
  logic               at_sword;
  logic               at_dragon;
  logic               at_exit;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    sword_d   = sword_q;
    slain_d   = slain_q;
    moves_d   = moves_q;
    d_d       = d_q;
    win_d     = win_q;
    tgt_row   = row_q;
    tgt_col   = col_q;

    valid_req = $onehot({bus.n, bus.s, bus.e, bus.w});
    blocked   = (bus.n && row_q == '0) || (bus.s && row_q == ROW_MAX) ||
                (bus.e && col_q == COL_MAX) || (bus.w && col_q == '0);

    if (bus.n) tgt_row = row_q - 1'b1;
    if (bus.s) tgt_row = row_q + 1'b1;
    if (bus.e) tgt_col = col_q + 1'b1;
    if (bus.w) tgt_col = col_q - 1'b1;

    accept    = valid_req && !blocked && (state_q == PLAY);
    at_sword  = (tgt_row == SWORD_R)  && (tgt_col == SWORD_C);
    at_dragon = (tgt_row == DRAGON_R) && (tgt_col == DRAGON_C);
    at_exit   = (tgt_row == EXIT_R)   && (tgt_col == EXIT_C);

    if (accept) begin
      row_d = tgt_row;
      col_d = tgt_col;
      if (at_sword) sword_d = 1'b1;
      // Rooms are distinct, so the sword can never be picked up on the dragon move.
      if (at_dragon && !slain_q) begin
        if (sword_q) begin
          slain_d = 1'b1;
        end else begin
          state_d = DEAD;
          d_d     = 1'b1;
        end
      end
      if (at_exit && slain_q) begin
        state_d = WON;
        win_d   = 1'b1;
      end
`ifdef MAZE_GAME_MOVE_LIMIT_EN
      moves_d = moves_q + 1'b1;
      // Running out of moves only kills a player who did not just win.
      if (moves_d == MOVES_W'(MOVE_LIMIT) && state_d != WON) begin
        state_d = DEAD;
        d_d     = 1'b1;
      end
`else
      moves_d = '0;
`endif
    end
  end

  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      state_q <= PLAY;
      row_q   <= START_R;
      col_q   <= START_C;
      sword_q <= 1'b0;
      slain_q <= 1'b0;
      moves_q <= '0;
      d_q     <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sword_q <= sword_d;
      slain_q <= slain_d;
      moves_q <= moves_d;
      d_q     <= d_d;
      win_q   <= win_d;
    end
  end

  assign bus.row   = row_q;
  assign bus.col   = col_q;
  assign bus.sword = sword_q;
  assign bus.slain = slain_q;
  assign bus.moves = moves_q;
  assign bus.d     = d_q;
  assign bus.win   = win_q;
endmodule

// File: tb/tb_maze_game.sv
// Directed bench for maze_game: a game-rules model checked every cycle plus literal spot checks.
module tb_maze_game;
  localparam int ROWS = 4, COLS = 4;
  localparam int START_ROW = 0, START_COL = 0;
  localparam int SWORD_ROW = 3, SWORD_COL = 0;
  localparam int DRAGON_ROW = 3, DRAGON_COL = 3;
  localparam int EXIT_ROW = 0, EXIT_COL = 3;
  localparam int MOVE_LIMIT = 12;
`ifdef MAZE_GAME_MOVE_LIMIT_EN
  localparam int HAS_LIMIT = 1;
`else
  localparam int HAS_LIMIT = 0;
`endif

  logic clock = 1'b0;
  logic R     = 1'b1;
  always #5 clock = ~clock;

  maze_game_if #(.ROWS(ROWS), .COLS(COLS), .MOVE_LIMIT(MOVE_LIMIT)) bus ();

  maze_game #(
    .ROWS(ROWS), .COLS(COLS),
    .START_ROW(START_ROW), .START_COL(START_COL),
    .SWORD_ROW(SWORD_ROW), .SWORD_COL(SWORD_COL),
    .DRAGON_ROW(DRAGON_ROW), .DRAGON_COL(DRAGON_COL),
    .EXIT_ROW(EXIT_ROW), .EXIT_COL(EXIT_COL),
    .MOVE_LIMIT(MOVE_LIMIT)
  ) dut (
    .clock(clock),
    .R(R),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Game state as the rules describe it.
  int m_row, m_col, m_moves;
  bit m_sword, m_slain, m_dead, m_won;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = START_ROW; m_col = START_COL; m_moves = 0;
    m_sword = 0; m_slain = 0; m_dead = 0; m_won = 0;
  endtask

  task automatic model_step(input bit n, input bit s, input bit e, input bit w);
    int nr, nc;
    if (m_dead || m_won) return;
    if (int'(n) + int'(s) + int'(e) + int'(w) != 1) return;
    nr = m_row + (s ? 1 : 0) - (n ? 1 : 0);
    nc = m_col + (e ? 1 : 0) - (w ? 1 : 0);
    if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) return;
    m_row = nr;
    m_col = nc;
    if (HAS_LIMIT != 0) m_moves++;
    if (nr == SWORD_ROW && nc == SWORD_COL) m_sword = 1;
    if (nr == DRAGON_ROW && nc == DRAGON_COL && !m_slain) begin
      if (m_sword) m_slain = 1;
      else m_dead = 1;
    end
    if (nr == EXIT_ROW && nc == EXIT_COL && m_slain && !m_dead) m_won = 1;
    if (HAS_LIMIT != 0 && m_moves == MOVE_LIMIT && !m_won) m_dead = 1;
  endtask

  always @(negedge clock) begin
    if (!R) begin
      check("row",   int'(bus.row),   m_row);
      check("col",   int'(bus.col),   m_col);
      check("sword", int'(bus.sword), int'(m_sword));
      check("slain", int'(bus.slain), int'(m_slain));
      check("moves", int'(bus.moves), m_moves);
      check("d",     int'(bus.d),     int'(m_dead));
      check("win",   int'(bus.win),   int'(m_won));
      check("d_win_exclusive", int'(bus.d & bus.win), 0);
    end
  end

  // Drives one request per clock; 'X' means n and e together, '0' means no request.
  task automatic play(input string dirs);
    bit n, s, e, w;
    for (int i = 0; i < dirs.len(); i++) begin
      n = (dirs[i] == "N") || (dirs[i] == "X");
      s = (dirs[i] == "S");
      e = (dirs[i] == "E") || (dirs[i] == "X");
      w = (dirs[i] == "W");
      @(negedge clock);
      #1;
      bus.n = n; bus.s = s; bus.e = e; bus.w = w;
      @(posedge clock);
      #1;
      model_step(n, s, e, w);
      $display("move %s -> row=%0d col=%0d sword=%0d slain=%0d moves=%0d d=%0d win=%0d",
               dirs.substr(i, i), bus.row, bus.col, bus.sword, bus.slain, bus.moves, bus.d, bus.win);
    end
    @(negedge clock);
    #1;
    bus.n = 0; bus.s = 0; bus.e = 0; bus.w = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    R = 1'b1;
    bus.n = 0; bus.s = 0; bus.e = 0; bus.w = 0;
    model_reset();
    @(negedge clock);
    #1;
    R = 1'b0;
  endtask

  initial begin
    bus.n = 0; bus.s = 0; bus.e = 0; bus.w = 0;
    model_reset();
    #12;
    check("rst_row", int'(bus.row), 0);
    check("rst_col", int'(bus.col), 0);
    check("rst_d",   int'(bus.d),   0);
    check("rst_win", int'(bus.win), 0);
    do_reset();

    play("EEE");
    check("eee_col", int'(bus.col), 3);
    check("eee_row", int'(bus.row), 0);
    check("eee_win_locked", int'(bus.win), 0);

    do_reset();
    play("SSS");
    check("quest_sword", int'(bus.sword), 1);
    play("EEE");
    check("quest_slain", int'(bus.slain), 1);
    check("quest_alive", int'(bus.d), 0);
    play("NNN");
    check("quest_win", int'(bus.win), 1);
    check("quest_moves", int'(bus.moves), HAS_LIMIT != 0 ? 9 : 0);
    play("S");
    check("won_frozen_row", int'(bus.row), 0);

    do_reset();
    play("EEESSS");
    check("dragon_d", int'(bus.d), 1);
    check("dragon_row", int'(bus.row), 3);
    check("dragon_col", int'(bus.col), 3);
    check("dragon_sword", int'(bus.sword), 0);
    play("NNN");
    check("dead_frozen_row", int'(bus.row), 3);
    check("dead_frozen_d", int'(bus.d), 1);

    do_reset();
    play("NX0");
    check("nomove_row", int'(bus.row), 0);
    check("nomove_col", int'(bus.col), 0);
    check("nomove_moves", int'(bus.moves), 0);
    play("E");
    check("after_nomove_col", int'(bus.col), 1);
    check("after_nomove_moves", int'(bus.moves), HAS_LIMIT);

    do_reset();
    play("ESWNESWNESWN");
    check("budget_d", int'(bus.d), HAS_LIMIT);
    check("budget_moves", int'(bus.moves), HAS_LIMIT != 0 ? 12 : 0);
    check("budget_row", int'(bus.row), 0);
    check("budget_col", int'(bus.col), 0);

    do_reset();
    play("SS");
    @(posedge clock);
    #3;
    R = 1'b1;
    #1;
    check("async_row", int'(bus.row), 0);
    check("async_col", int'(bus.col), 0);
    check("async_sword", int'(bus.sword), 0);
    check("async_d", int'(bus.d), 0);
    check("async_win", int'(bus.win), 0);
    model_reset();
    @(negedge clock);
    #1;
    R = 1'b0;
    play("E");
    check("post_async_col", int'(bus.col), 1);

    @(negedge clock);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_game.md
# maze_game

Parametrised grid adventure-game controller: player moves one room per clock through a ROWS×COLS grid under n/s/e/w control, picks up a sword, must slay a dragon, and then reach the exit to win. Successor to the fixed-room adventure FSM, with configurable grid size, room placement, a locked exit and an optional move budget. Drives the same `d` / `win` status lines that the game test environment monitors.

## Interface
- ROWS, 4, grid rows (≥2)
- COLS, 4, grid columns (≥2)
- START_ROW / START_COL, 0 / 0, reset room
- SWORD_ROW / SWORD_COL, 3 / 0, sword room
- DRAGON_ROW / DRAGON_COL, 3 / 3, dragon room
- EXIT_ROW / EXIT_COL, 0 / 3, exit room
- MOVE_LIMIT, 12, accepted-move budget (used only with MAZE_GAME_MOVE_LIMIT_EN)

- clock  in  1  sole clock, rising edge
- R  in  1  reset, asynchronous, active-high
- n, s, e, w  in  1 each  direction requests, sampled at posedge clock
- row  out  $clog2(ROWS)  current row (0 = north edge)
- col  out  $clog2(COLS)  current column (0 = west edge)
- sword  out  1  player holds sword
- slain  out  1  dragon has been killed
- moves  out  $clog2(MOVE_LIMIT+1)  accepted-move count
- d  out  1  player dead
- win  out  1  player won

## Operation
- States: PLAY, DEAD, WON. DEAD and WON are absorbing until R.
- Reset values: row=START_ROW, col=START_COL, sword=0, slain=0, moves=0, d=0, win=0, state PLAY.
- Valid request: exactly one of n/s/e/w high. Zero or multiple high → no move.
- n: row−1; s: row+1; e: col+1; w: col−1. Move off the grid edge → blocked, no move.
- Accepted move = valid request, not blocked, state PLAY. Only accepted moves change position or count.
- Target-room evaluation, applied on the same edge as the move:
  - sword room: sword←1 (sticky).
  - dragon room, slain=0: sword=1 → slain←1, stay PLAY; sword=0 → DEAD, d←1.
  - dragon room, slain=1: ordinary room.
  - exit room: slain=1 → WON, win←1; slain=0 → locked, ordinary room.
- Position still updates on the killing/winning move; afterwards all outputs are frozen.
- Elaboration-time $error if sword, dragon, exit or start rooms coincide (start may not equal sword, dragon or exit), or if any coordinate is out of range.

## Timing
- All outputs are registered; an input sampled at edge k is reflected in outputs immediately after edge k (1-cycle latency, no combinational paths from inputs).
- R asserts outputs to reset values immediately, independent of clock; deassertion is synchronised by the integrator; first move is sampled at the first edge with R low.
- d and win are never both 1.

## Configuration
- MAZE_GAME_MOVE_LIMIT_EN defined: moves increments on every accepted move. The accepted move that makes moves==MOVE_LIMIT → DEAD (d←1), unless that same move produces WON, in which case WON wins and d stays 0. Dragon death on that move → DEAD as normal.
- Not defined: no counter; moves tied to 0; no move budget.

## Test plan
- Defaults, reset, "EEE" → row=0, col=3, win=0 (exit locked), state PLAY.
- "SSSEEENNN" → sword=1 after 3rd edge, slain=1 after 6th, d=0, win=1 after 9th edge; moves=9 with macro.
- "EEESSS" → d=1 after 6th edge at (3,3), sword=0; further "NNN" leaves row/col/d unchanged.
- "N" at (0,0), then n=e=1 together, then all low → no movement, moves=0; next "E" → col=1, moves=1.
- With macro, "ESWN"×3 → d=1 after 12th edge at (0,0), moves=12; without macro same stimulus → d=0, moves=0.
- "SS" then R raised mid-cycle → row=0, col=0, sword=0, d=0, win=0 before the next edge; after R low, "E" → col=1.
